// File: rtl/operand_sweep_ctrl.sv
// Sequencer that steps operands {a,b,c,d} through every combination, each held HOLD
// cycles, then drives a trailing {a=0,b=0} vector. Optional stall input under SWEEP_PAUSE_EN.
module operand_sweep_ctrl #(
   parameter int D_WIDTH = 2,
   parameter int HOLD    = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
`ifdef SWEEP_PAUSE_EN
   input  logic               pause,
`endif
   output logic               a,
   output logic               b,
   output logic               c,
   output logic [D_WIDTH-1:0] d,
   output logic               vec_valid,
   output logic [D_WIDTH+2:0] vec_idx,
   output logic               busy,
   output logic               done,
   output logic               aborted
);

   localparam int VW    = D_WIDTH + 3;
   localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [VW-1:0]    vec, vec_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             aborted_nxt;
   logic             stall;

`ifdef SWEEP_PAUSE_EN
   assign stall = pause;
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         vec     <= '0;
         cnt     <= '0;
         aborted <= 1'b0;
      end else begin
         state   <= state_nxt;
         vec     <= vec_nxt;
         cnt     <= cnt_nxt;
         aborted <= aborted_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      vec_nxt     = vec;
      cnt_nxt     = cnt;
      aborted_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = SWEEP;
               vec_nxt   = '0;
               cnt_nxt   = RELOAD;
            end
         end
         SWEEP: begin
            if (abort) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               aborted_nxt = 1'b1;
            end else if (!stall) begin
               if (cnt == '0) begin
                  cnt_nxt = RELOAD;
                  if (vec == '1) begin
                     // trailing vector clears a and b, keeps c and d
                     state_nxt = FINAL;
                     vec_nxt   = {2'b00, vec[VW-3:0]};
                  end else begin
                     vec_nxt = vec + 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
         end
         FINAL: begin
            if (abort) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               aborted_nxt = 1'b1;
            end else if (!stall) begin
               if (cnt == '0) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      a         = vec[VW-1];
      b         = vec[VW-2];
      c         = vec[VW-3];
      d         = vec[D_WIDTH-1:0];
      vec_valid = (state == SWEEP) || (state == FINAL);
      vec_idx   = (state == SWEEP) ? vec : '0;
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

endmodule

// File: tb/tb_operand_sweep_ctrl.sv
// Directed bench for operand_sweep_ctrl: HOLD=5 and HOLD=1 instances, cycle-indexed
// checks against hand-computed vector timing, abort, reset and optional pause.
module tb_operand_sweep_ctrl;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic start0 = 1'b0, abort0 = 1'b0, pause0 = 1'b0;
   logic start1 = 1'b0, abort1 = 1'b0, pause1 = 1'b0;

   logic       a0, b0, c0, vv0, busy0, done0, ab0;
   logic [1:0] d0;
   logic [4:0] idx0;
   logic       a1, b1, c1, vv1, busy1, done1, ab1;
   logic [1:0] d1;
   logic [4:0] idx1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ndone0 = 0, nab0 = 0, ndone1 = 0;

   always #5 clock = ~clock;

   operand_sweep_ctrl #(.D_WIDTH(2), .HOLD(5)) dut0 (
      .clock(clock), .reset_n(reset_n), .start(start0), .abort(abort0),
`ifdef SWEEP_PAUSE_EN
      .pause(pause0),
`endif
      .a(a0), .b(b0), .c(c0), .d(d0), .vec_valid(vv0), .vec_idx(idx0),
      .busy(busy0), .done(done0), .aborted(ab0)
   );

   operand_sweep_ctrl #(.D_WIDTH(2), .HOLD(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .start(start1), .abort(abort1),
`ifdef SWEEP_PAUSE_EN
      .pause(pause1),
`endif
      .a(a1), .b(b1), .c(c1), .d(d1), .vec_valid(vv1), .vec_idx(idx1),
      .busy(busy1), .done(done1), .aborted(ab1)
   );

   wire [4:0] ops0 = {a0, b0, c0, d0};
   wire [4:0] ops1 = {a1, b1, c1, d1};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (done0) ndone0++;
      if (ab0) nab0++;
      if (done1) ndone1++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic kick0();
      cyc = 0; ndone0 = 0; nab0 = 0;
      start0 = 1'b1;
      step();
      start0 = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      check_eq("rst_ops", ops0, 0);
      check_eq("rst_idx", idx0, 0);
      check_eq("rst_flags", {vv0, busy0, done0, ab0}, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      step();

      // full sweep, HOLD=5
      kick0();
      check_eq("t1_c1_ops", ops0, 0);
      check_eq("t1_c1_vv_busy", {vv0, busy0}, 2'b11);
      run_to(5);   check_eq("t1_c5_ops", ops0, 0);
      run_to(6);   check_eq("t1_c6_ops", ops0, 1);
      check_eq("t1_c6_idx", idx0, 1);
      run_to(155); check_eq("t1_c155_idx", idx0, 30);
      run_to(156); check_eq("t1_c156_idx", idx0, 31);
      run_to(160); check_eq("t1_c160_ops", ops0, 31);
      run_to(161); check_eq("t1_c161_ops", ops0, 7);
      check_eq("t1_c161_idx", idx0, 0);
      check_eq("t1_c161_vv", vv0, 1);
      run_to(165); check_eq("t1_c165_vv_done", {vv0, done0}, 2'b10);
      run_to(166); check_eq("t1_c166_done", done0, 1);
      check_eq("t1_c166_vv_busy", {vv0, busy0}, 2'b01);
      run_to(167); check_eq("t1_c167_busy_done", {busy0, done0}, 0);
      check_eq("t1_c167_ops", ops0, 7);
      check_eq("t1_ndone", ndone0, 1);

      // start and abort together in IDLE: abort wins, no pulse
      start0 = 1'b1; abort0 = 1'b1;
      step();
      start0 = 1'b0; abort0 = 1'b0;
      check_eq("t2_sa_busy_ab", {busy0, ab0}, 0);

      // abort on cycle 40 (vector 7)
      kick0();
      run_to(40);  check_eq("t2_c40_idx", idx0, 7);
      abort0 = 1'b1;
      step();
      abort0 = 1'b0;
      check_eq("t2_c41_ab", ab0, 1);
      check_eq("t2_c41_busy_vv", {busy0, vv0}, 0);
      check_eq("t2_c41_ops", ops0, 7);
      run_to(42);  check_eq("t2_c42_ab", ab0, 0);
      abort0 = 1'b1;
      step();
      abort0 = 1'b0;
      check_eq("t2_idle_abort_ignored", ab0, 0);
      run_to(170);
      check_eq("t2_ndone", ndone0, 0);
      check_eq("t2_nab", nab0, 1);

      // start held high throughout the sweep
      cyc = 0; ndone0 = 0; nab0 = 0;
      start0 = 1'b1;
      step();
      run_to(100); check_eq("t3_c100_idx", idx0, 19);
      run_to(166); check_eq("t3_c166_done", done0, 1);
      run_to(167); check_eq("t3_c167_busy", busy0, 0);
      run_to(168);
      check_eq("t3_c168_restart", {busy0, vv0, idx0}, {2'b11, 5'd0});
      check_eq("t3_ndone", ndone0, 1);
      start0 = 1'b0; abort0 = 1'b1;
      step();
      abort0 = 1'b0;
      check_eq("t3_abort_ab", ab0, 1);
      step();

      // HOLD=1
      cyc = 0; ndone1 = 0;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         run_to(k);
         check_eq("t4_idx", idx1, k - 1);
      end
      run_to(33);
      check_eq("t4_c33_final", {vv1, ops1, idx1}, {1'b1, 5'd7, 5'd0});
      run_to(34);
      check_eq("t4_c34_done", {done1, vv1}, 2'b10);
      run_to(36);
      check_eq("t4_ndone", ndone1, 1);

      // asynchronous reset mid-sweep
      kick0();
      run_to(80);
      check_eq("t5_c80_pre_busy", busy0, 1);
      reset_n = 1'b0;
      #1;
      check_eq("t5_async_ops", ops0, 0);
      check_eq("t5_async_flags", {vv0, busy0, done0, ab0, idx0}, 0);
      run_to(83);
      reset_n = 1'b1;
      run_to(90);
      check_eq("t5_idle", busy0, 0);
      check_eq("t5_no_pulses", ndone0 + nab0, 0);

`ifdef SWEEP_PAUSE_EN
      // pause on cycles 10-19 stretches vector 1 to cycles 6-20
      kick0();
      run_to(10);
      pause0 = 1'b1;
      run_to(15); check_eq("t6_c15_idx", idx0, 1);
      check_eq("t6_c15_vv", vv0, 1);
      run_to(20);
      pause0 = 1'b0;
      check_eq("t6_c20_idx", idx0, 1);
      run_to(21); check_eq("t6_c21_idx", idx0, 2);
      run_to(175); check_eq("t6_c175_done", done0, 0);
      run_to(176); check_eq("t6_c176_done", done0, 1);
      run_to(178); check_eq("t6_ndone", ndone0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
